// File: rtl/stark_const_squash_if.sv
// stark_const_squash_if
//   Bundles the fetch-group input handshake and the squashed-group output
//   handshake of the constant-slot squash stage.
//   Parameters mirror those of stark_const_squash and must match it.
//   Input side : in_valid/in_ready, in_line, in_group, in_slot_v, in_cpos, in_csz
//   Output side: out_valid/out_ready, out_line, out_group, out_nop, out_fault,
//                out_fault_lane
//   master: the aligner/decoder side (drives inputs, consumes outputs)
//   slave : the squash stage itself
interface stark_const_squash_if #(
  parameter int WIDTH      = 4,
  parameter int LINE_SLOTS = 16,
  parameter int NCONST     = 2,
  parameter int LINE_W     = 26
);
  localparam int SW = $clog2(LINE_SLOTS);
  localparam int GW = $clog2(LINE_SLOTS / WIDTH);
  localparam int LW = $clog2(WIDTH);

  logic                       in_valid;
  logic                       in_ready;
  logic [LINE_W-1:0]          in_line;
  logic [GW-1:0]              in_group;
  logic [WIDTH-1:0]           in_slot_v;
  logic [WIDTH*NCONST*SW-1:0] in_cpos;
  logic [WIDTH*NCONST*2-1:0]  in_csz;

  logic                       out_valid;
  logic                       out_ready;
  logic [LINE_W-1:0]          out_line;
  logic [GW-1:0]              out_group;
  logic [WIDTH-1:0]           out_nop;
  logic                       out_fault;
  logic [LW-1:0]              out_fault_lane;

  modport master (
    output in_valid, in_line, in_group, in_slot_v, in_cpos, in_csz, out_ready,
    input  in_ready, out_valid, out_line, out_group, out_nop, out_fault,
           out_fault_lane
  );

  modport slave (
    input  in_valid, in_line, in_group, in_slot_v, in_cpos, in_csz, out_ready,
    output in_ready, out_valid, out_line, out_group, out_nop, out_fault,
           out_fault_lane
  );
endinterface

// File: rtl/stark_const_squash.sv
// stark_const_squash
//   Constant-slot squash stage between the instruction aligner and the
//   per-lane decoders. Each lane of a WIDTH-wide fetch group may describe up
//   to NCONST trailing constant words (absolute slot + size). Slots covered
//   by those constants become NOPs, both in the current group and in later
//   groups of the same cache line (carried in sq_r). Illegal descriptors
//   raise out_fault and are excluded from squashing.
//   Ports:
//     clk   - clock
//     rst   - synchronous active-high reset
//     flush - drops the held output and the carried squash state
//     bus   - slave side of stark_const_squash_if (input group handshake,
//             registered output group handshake, fault report)
module stark_const_squash #(
  parameter int WIDTH      = 4,
  parameter int LINE_SLOTS = 16,
  parameter int NCONST     = 2,
  parameter int LINE_W     = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  stark_const_squash_if.slave   bus
);
  localparam int SW = $clog2(LINE_SLOTS);
  localparam int GW = $clog2(LINE_SLOTS / WIDTH);
  localparam int LW = $clog2(WIDTH);

  // Slots [cpos, cpos+csz) as a line-wide mask; sums kept at SW+1 bits so
  // a constant running past the line end never wraps onto low slots.
  function automatic logic [LINE_SLOTS-1:0] cover_mask(input logic [SW-1:0] cpos,
                                                       input logic [1:0]    csz);
    logic [LINE_SLOTS-1:0] m;
    logic [SW:0]           lo;
    logic [SW:0]           hi;
    lo = {1'b0, cpos};
    hi = lo + {{(SW-1){1'b0}}, csz};
    for (int s = 0; s < LINE_SLOTS; s++) begin
      m[s] = ((SW+1)'(s) >= lo) && ((SW+1)'(s) < hi);
    end
    return m;
  endfunction

  // A present descriptor is illegal if it does not follow its instruction,
  // runs past the line, or uses the reserved size.
  function automatic logic desc_fault(input logic [SW-1:0] cpos,
                                      input logic [1:0]    csz,
                                      input logic [SW-1:0] slot);
    logic [SW:0] hi;
    hi = {1'b0, cpos} + {{(SW-1){1'b0}}, csz};
    return (csz != 2'd0) &&
           ((cpos <= slot) || (hi > (SW+1)'(LINE_SLOTS)) || (csz == 2'd3));
  endfunction

  // Carried line state
  logic [LINE_SLOTS-1:0] sq_r;
  logic [LINE_W-1:0]     cur_line_r;
  logic [GW-1:0]         cur_group_r;
  logic                  cur_v_r;

  // Output registers
  logic                  out_valid_r;
  logic [LINE_W-1:0]     out_line_r;
  logic [GW-1:0]         out_group_r;
  logic [WIDTH-1:0]      out_nop_r;
  logic                  out_fault_r;
  logic [LW-1:0]         out_fault_lane_r;

  // Combinational results for the presented group
  logic [LINE_SLOTS-1:0] base_s;
  logic [LINE_SLOTS-1:0] cover_s;
  logic [WIDTH-1:0]      nop_s;
  logic                  fault_s;
  logic [LW-1:0]         fault_lane_s;
  logic                  accept_s;
  logic                  in_ready_s;

  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s && !flush;

  // Per-lane NOP, squash-mask and fault evaluation, walking lanes in order
  // so a lane only sees constants claimed by earlier live lanes.
  always_comb begin
    logic [SW-1:0] slot;
    logic [SW-1:0] cpos;
    logic [1:0]    csz;
    logic          lane_nop;
    logic          lf;
    logic          live;
    slot         = '0;
    cpos         = '0;
    csz          = 2'd0;
    lane_nop     = 1'b0;
    lf           = 1'b0;
    live         = 1'b0;
    // Only a strictly later group of the same tracked line inherits the mask;
    // same-group or backward re-entry restarts the line.
    base_s       = (cur_v_r && (bus.in_line == cur_line_r) && (bus.in_group > cur_group_r))
                   ? sq_r : '0;
    cover_s      = '0;
    nop_s        = '0;
    fault_s      = 1'b0;
    fault_lane_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      slot     = {bus.in_group, LW'(i)};
      lane_nop = !bus.in_slot_v[i] || base_s[slot] || cover_s[slot];
      nop_s[i] = lane_nop;
      for (int k = 0; k < NCONST; k++) begin
        cpos         = bus.in_cpos[(i*NCONST+k)*SW +: SW];
        csz          = bus.in_csz[(i*NCONST+k)*2 +: 2];
        lf           = !lane_nop && desc_fault(cpos, csz, slot);
        live         = !lane_nop && (csz != 2'd0) && !lf;
        cover_s      = cover_s | (live ? cover_mask(cpos, csz) : '0);
        fault_lane_s = (lf && !fault_s) ? LW'(i) : fault_lane_s;
        fault_s      = fault_s || lf;
      end
    end
  end

  // Output stage and carried squash state; flush outranks everything but rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r      <= 1'b0;
      out_line_r       <= '0;
      out_group_r      <= '0;
      out_nop_r        <= '1;
      out_fault_r      <= 1'b0;
      out_fault_lane_r <= '0;
      sq_r             <= '0;
      cur_line_r       <= '0;
      cur_group_r      <= '0;
      cur_v_r          <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      sq_r        <= '0;
      cur_v_r     <= 1'b0;
    end else if (accept_s) begin
      out_valid_r      <= 1'b1;
      out_line_r       <= bus.in_line;
      out_group_r      <= bus.in_group;
      out_nop_r        <= nop_s;
      out_fault_r      <= fault_s;
      out_fault_lane_r <= fault_lane_s;
      sq_r             <= base_s | cover_s;
      cur_line_r       <= bus.in_line;
      cur_group_r      <= bus.in_group;
      cur_v_r          <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_line       = out_line_r;
  assign bus.out_group      = out_group_r;
  assign bus.out_nop        = out_nop_r;
  assign bus.out_fault      = out_fault_r;
  assign bus.out_fault_lane = out_fault_lane_r;
endmodule

// File: tb/tb_stark_const_squash.sv
// tb_stark_const_squash
//   Directed bench for stark_const_squash with default parameters
//   (WIDTH=4, LINE_SLOTS=16, NCONST=2, LINE_W=26). Inputs change 1 time unit
//   after a rising edge; outputs are sampled at the same point.
module tb_stark_const_squash;
  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  stark_const_squash_if bus ();

  stark_const_squash dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [25:0] LA = 26'h00000A;
  localparam logic [25:0] LB = 26'h00000B;
  localparam logic [25:0] LC = 26'h00000C;
  localparam logic [25:0] LD = 26'h00000D;
  localparam logic [25:0] LE = 26'h00000E;
  localparam logic [25:0] LF = 26'h00000F;
  localparam logic [25:0] LG = 26'h000101;
  localparam logic [25:0] LH = 26'h000202;
  localparam logic [25:0] LJ = 26'h000303;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid  = 1'b0;
    bus.in_line   = '0;
    bus.in_group  = '0;
    bus.in_slot_v = '0;
    bus.in_cpos   = '0;
    bus.in_csz    = '0;
  endtask

  task automatic grp(input logic [25:0] line, input logic [1:0] g, input logic [3:0] v);
    bus.in_valid  = 1'b1;
    bus.in_line   = line;
    bus.in_group  = g;
    bus.in_slot_v = v;
    bus.in_cpos   = '0;
    bus.in_csz    = '0;
  endtask

  task automatic desc(input int lane, input int k, input int cpos, input int csz);
    bus.in_cpos[(lane*2+k)*4 +: 4] = 4'(cpos);
    bus.in_csz[(lane*2+k)*2 +: 2]  = 2'(csz);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    clear_in();
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_nop", 32'(bus.out_nop), 32'hF);
    chk("rst_fault", 32'(bus.out_fault), 32'h0);
    chk("rst_flane", 32'(bus.out_fault_lane), 32'h0);
    chk("rst_line", 32'(bus.out_line), 32'h0);
    chk("rst_group", 32'(bus.out_group), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Same-group squash, 1-cycle latency
    grp(LA, 2'd0, 4'hF);
    desc(0, 0, 1, 2);
    tick();
    chk("same_valid", 32'(bus.out_valid), 32'h1);
    chk("same_nop", 32'(bus.out_nop), 32'h6);
    chk("same_fault", 32'(bus.out_fault), 32'h0);
    chk("same_line", 32'(bus.out_line), 32'(LA));
    chk("same_group", 32'(bus.out_group), 32'h0);

    // Cross-group carry
    grp(LA, 2'd0, 4'hF);
    desc(3, 0, 4, 2);
    tick();
    chk("carry_g0_nop", 32'(bus.out_nop), 32'h0);
    grp(LA, 2'd1, 4'hF);
    tick();
    chk("carry_g1_nop", 32'(bus.out_nop), 32'h3);
    chk("carry_g1_group", 32'(bus.out_group), 32'h1);

    // Line change
    grp(LA, 2'd0, 4'hF);
    desc(3, 0, 4, 2);
    tick();
    grp(LB, 2'd1, 4'hF);
    tick();
    chk("linechg_nop", 32'(bus.out_nop), 32'h0);
    chk("linechg_line", 32'(bus.out_line), 32'(LB));

    // Backward re-entry clears the carried mask
    grp(LA, 2'd1, 4'hF);
    desc(3, 0, 8, 1);
    tick();
    chk("back_g1_nop", 32'(bus.out_nop), 32'h0);
    grp(LA, 2'd0, 4'hF);
    tick();
    chk("back_g0_nop", 32'(bus.out_nop), 32'h0);
    grp(LA, 2'd2, 4'hF);
    tick();
    chk("back_g2_nop", 32'(bus.out_nop), 32'h0);

    // Fault: constant not after its instruction
    grp(LC, 2'd0, 4'hF);
    desc(2, 0, 2, 2);
    tick();
    chk("fpos_fault", 32'(bus.out_fault), 32'h1);
    chk("fpos_lane", 32'(bus.out_fault_lane), 32'h2);
    chk("fpos_nop", 32'(bus.out_nop), 32'h0);

    // Fault: crosses the line end, must not squash slot 15 later
    grp(LD, 2'd0, 4'hF);
    desc(1, 0, 15, 2);
    tick();
    chk("fcross_fault", 32'(bus.out_fault), 32'h1);
    chk("fcross_lane", 32'(bus.out_fault_lane), 32'h1);
    chk("fcross_nop", 32'(bus.out_nop), 32'h0);
    grp(LD, 2'd3, 4'hF);
    tick();
    chk("fcross_g3_nop", 32'(bus.out_nop), 32'h0);
    chk("fcross_g3_fault", 32'(bus.out_fault), 32'h0);

    // Fault: reserved size, plus a second fault on a higher lane
    grp(LE, 2'd0, 4'hF);
    desc(0, 0, 1, 3);
    desc(3, 1, 0, 1);
    tick();
    chk("frsv_fault", 32'(bus.out_fault), 32'h1);
    chk("frsv_lane", 32'(bus.out_fault_lane), 32'h0);
    chk("frsv_nop", 32'(bus.out_nop), 32'h0);

    // Descriptors of NOP lanes are ignored
    grp(LF, 2'd0, 4'b1011);
    desc(0, 0, 1, 1);
    desc(1, 0, 0, 1);
    desc(2, 1, 3, 1);
    tick();
    chk("nopdesc_nop", 32'(bus.out_nop), 32'h6);
    chk("nopdesc_fault", 32'(bus.out_fault), 32'h0);

    // Backpressure
    grp(LG, 2'd0, 4'hF);
    desc(0, 0, 4, 1);
    tick();
    chk("bp_first_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_first_nop", 32'(bus.out_nop), 32'h0);
    bus.out_ready = 1'b0;
    grp(LG, 2'd1, 4'hF);
    #1;
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_group", 32'(bus.out_group), 32'h0);
      chk("bp_hold_nop", 32'(bus.out_nop), 32'h0);
      chk("bp_hold_ready", 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 32'(bus.in_ready), 32'h1);
    tick();
    chk("bp_g1_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_g1_group", 32'(bus.out_group), 32'h1);
    chk("bp_g1_nop", 32'(bus.out_nop), 32'h1);
    grp(LG, 2'd2, 4'hF);
    tick();
    chk("bp_g2_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_g2_group", 32'(bus.out_group), 32'h2);
    chk("bp_g2_nop", 32'(bus.out_nop), 32'h0);
    clear_in();
    tick();
    chk("bp_drain_valid", 32'(bus.out_valid), 32'h0);

    // Flush drops the simultaneous input and the carried mask
    grp(LH, 2'd0, 4'hF);
    desc(3, 0, 4, 2);
    tick();
    chk("fl_pre_valid", 32'(bus.out_valid), 32'h1);
    grp(LH, 2'd0, 4'hF);
    desc(3, 0, 4, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(bus.out_valid), 32'h0);
    grp(LH, 2'd1, 4'hF);
    tick();
    chk("fl_next_valid", 32'(bus.out_valid), 32'h1);
    chk("fl_next_nop", 32'(bus.out_nop), 32'h0);

    // Reset mid-stream
    grp(LJ, 2'd0, 4'hF);
    desc(1, 0, 0, 1);
    desc(3, 0, 4, 2);
    tick();
    chk("mr_pre_fault", 32'(bus.out_fault), 32'h1);
    chk("mr_pre_lane", 32'(bus.out_fault_lane), 32'h1);
    chk("mr_pre_line", 32'(bus.out_line), 32'(LJ));
    grp(LJ, 2'd1, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 32'(bus.out_valid), 32'h0);
    chk("mr_nop", 32'(bus.out_nop), 32'hF);
    chk("mr_fault", 32'(bus.out_fault), 32'h0);
    chk("mr_lane", 32'(bus.out_fault_lane), 32'h0);
    chk("mr_line", 32'(bus.out_line), 32'h0);
    chk("mr_group", 32'(bus.out_group), 32'h0);
    grp(LJ, 2'd1, 4'hF);
    tick();
    chk("mr_after_valid", 32'(bus.out_valid), 32'h1);
    chk("mr_after_nop", 32'(bus.out_nop), 32'h0);
    clear_in();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stark_const_squash.md
# stark_const_squash

Parametrised constant-slot squash stage that sits between the instruction aligner and the per-lane decoders in the Stark front end. It accepts WIDTH-wide fetch groups taken from a cache line of LINE_SLOTS 32-bit slots. Each lane reports where its trailing constant words live. The block marks those slots as NOPs in the current group and in later groups of the same line, tracking the squash state across groups. Output is one registered pipeline stage with a valid/ready handshake, plus a fault report for illegal constant placement.

## Interface
Parameters:
- WIDTH, 4: lanes per fetch group; power of two.
- LINE_SLOTS, 16: 32-bit slots per cache line; power of two, multiple of WIDTH.
- NCONST, 2: constant descriptors per lane.
- LINE_W, 26: line-address tag width.
- SW = log2(LINE_SLOTS); GW = log2(LINE_SLOTS/WIDTH). Both are derived.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; discards state and output.
- in_valid  in  1  input group valid.
- in_ready  out  1  stage can accept the group.
- in_line  in  LINE_W  line-address tag of the group.
- in_group  in  GW  group index within the line.
- in_slot_v  in  WIDTH  per-lane slot valid.
- in_cpos  in  WIDTH*NCONST*SW  first slot of each constant, absolute within the line.
- in_csz  in  WIDTH*NCONST*2  constant size in slots: 0 none, 1, 2; 3 is reserved.
- out_valid  out  1  output group valid.
- out_ready  in  1  downstream accepts.
- out_line  out  LINE_W  registered in_line.
- out_group  out  GW  registered in_group.
- out_nop  out  WIDTH  lane is a NOP: invalid slot or squashed constant.
- out_fault  out  1  illegal constant descriptor in the group.
- out_fault_lane  out  log2(WIDTH)  lowest faulting lane.

## Operation
- Lane i occupies slot s(i) = in_group*WIDTH + i.
- Base mask:
  - base = sq when cur_v, in_line == cur_line and in_group > cur_group.
  - Otherwise base = 0. Backward or same-group re-entry starts a fresh line.
- Lane i is a NOP when any of these holds:
  - !in_slot_v[i];
  - base[s(i)];
  - some lane j < i that is not itself a NOP has a constant k covering s(i), i.e. cpos ≤ s(i) < cpos + csz.
- A NOP lane's descriptors are ignored. A constant slot cannot emit constants.
- Fault on a non-NOP lane descriptor with csz != 0 when any of these holds:
  - cpos ≤ s(i): the constant is not after its instruction;
  - cpos + csz > LINE_SLOTS: the constant crosses the line;
  - csz == 3.
- On a fault:
  - out_fault=1 and out_fault_lane = lowest faulting lane;
  - the faulting descriptor does not contribute to squashing;
  - out_nop is unaffected.
- On an accepted group, state updates as follows:
  - sq ← base | all covered slots of non-NOP, non-faulting descriptors;
  - cur_line ← in_line, cur_group ← in_group, cur_v ← 1.
- Covered slots may lie in later groups. They squash those lanes when the next groups of the same line arrive.
- Arithmetic: cpos + csz is evaluated at SW+1 bits, with no wrap.

## Timing
- Reset values:
  - out_valid=0, out_nop=all ones, out_fault=0, out_fault_lane=0;
  - out_line=0, out_group=0;
  - sq=0, cur_v=0.
- in_ready = !out_valid | out_ready. This is combinational, with no skid buffer.
- Accept when in_valid & in_ready & !flush.
  - Outputs register on the next edge: 1-cycle latency.
  - sq and cur_* update on the same edge.
- With out_valid & !out_ready, all outputs hold stable and no state changes.
- When out_ready is high and there is no new accept, out_valid falls on the next edge.
- flush has priority over everything except rst:
  - next edge gives out_valid=0 and cur_v=0, with sq cleared;
  - a simultaneous input is dropped.
- rst mid-stream returns to the reset values on the next edge, regardless of handshake.
- A group that is fully NOP is still passed downstream with out_valid=1.

## Test plan
- Single group, same group: WIDTH=4, group 0, all lanes valid, lane0 cpos=1 csz=2 -> out_nop=4'b0110, out_fault=0, latency 1 cycle.
- Cross-group carry: line A group0, lane3 cpos=4 csz=2, then line A group1 all valid -> group1 out_nop=4'b0011.
- Line change and backward re-entry:
  - repeat the previous case but with the second group on line B -> out_nop=0;
  - line A group1 followed by line A group0 -> the mask is cleared.
- Faults:
  - lane2 cpos=2 -> out_fault=1, lane=2;
  - lane1 cpos=15 csz=2 -> fault, lane=1;
  - csz=3 -> fault.
  - In each case no squash is produced by the faulting descriptor.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, sq unchanged; release -> one transfer per cycle, no loss or duplication.
- Flush/reset: flush asserted in the same cycle as an accepted-looking input -> out_valid=0 next cycle; the following same-line group sees base=0. rst mid-stream -> all reset values.
